instr_fetch_unit: RTL and testbench

Requester side of the instruction memory interface. Owns the program counter and drives the word address to the combinational instruction memory. Captures the returned instruction words into a small in-order queue and presents them to decode with a valid/ready handshake. Accepts branch/jump redirects that flush the queue and reload the PC.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 67 ++++++
 tb/tb_instr_fetch_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
package cpu_pkg;

  localparam int          WORD_W           = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // One queued fetch: the byte address it came from and the word returned.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto an instruction-word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched entries with push/pop, a one-cycle flush and an
// occupancy count. The head output reads as zero while the queue is empty.
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic                     full
);

  localparam int                PW       = $clog2(DEPTH);
  localparam int                CW       = PW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign dout  = valid ? mem[rd_ptr] : '0;

  // Entry storage; contents are meaningless until counted in, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush empties the queue and rewinds both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory,
// queues returned words in order and hands them to decode with valid/ready.
// A redirect flushes the queue and reloads the PC with the aligned target.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [WORD_W-1:0]      pc_addr_o,
  input  logic [WORD_W-1:0]      instr_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WORD_W-1:0]      instr_o,
  output logic [WORD_W-1:0]      pc_o,
  input  logic                   redirect_i,
  input  logic [WORD_W-1:0]      redirect_pc_i,
  output logic [$clog2(DEPTH):0] count_o
);

  logic [WORD_W-1:0] pc_q;
  logic              deq;
  logic              enq;
  logic              q_full;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head_entry;

  assign pc_addr_o = pc_q;
  assign deq       = valid_o & ready_i;
  // A full queue can still take a fetch when its head leaves this cycle.
  assign enq       = !redirect_i & (!q_full | deq);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = instr_i;
  assign pc_o           = head_entry.pc;
  assign instr_o        = head_entry.instr;

  // Program counter: redirect wins, otherwise step one word per accepted fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= align_word(redirect_pc_i);
    end else if (enq) begin
      pc_q <= pc_q + WORD_W'(INSTR_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (2 * WORD_W)
  ) u_queue (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_i),
    .din   (wr_entry),
    .dout  (head_entry),
    .count (count_o),
    .valid (valid_o),
    .full  (q_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table walked one clock per
// row, plus hand-written sequences for async reset and the startup wait.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [1:0]  count_o;

  int total;
  int passed;

  instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .count_o       (count_o)
  );

  // Memory model: word k holds k+1.
  assign instr_i = (pc_addr_o >> 2) + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_count;
    logic [31:0] e_pcaddr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic [31:0] e_count,
                           input logic [31:0] e_pcaddr, input logic [31:0] e_pc,
                           input logic [31:0] e_instr);
    check({tag, ".valid"},   {31'd0, valid_o}, {31'd0, e_valid});
    check({tag, ".count"},   {30'd0, count_o}, e_count);
    check({tag, ".pc_addr"}, pc_addr_o,        e_pcaddr);
    check({tag, ".pc"},      pc_o,             e_pc);
    check({tag, ".instr"},   instr_o,          e_instr);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_i = 1'b0;
    ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;

    //          rst   rdy   redir rpc            valid cnt pc_addr        pc             instr
    // reset held two cycles
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        32'h0};
    // streaming with ready high: one per cycle, count stays 1
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1, 32'h4,        32'h0,        32'h1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1, 32'h8,        32'h4,        32'h2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1, 32'hC,        32'h8,        32'h3};
    // reset again, then backpressure for five cycles
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1, 32'h4,        32'h0,        32'h1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h8,        32'h0,        32'h1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h8,        32'h0,        32'h1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h8,        32'h0,        32'h1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h8,        32'h0,        32'h1};
    // full queue, simultaneous push and pop
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2, 32'hC,        32'h4,        32'h2};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2, 32'h10,       32'h8,        32'h3};
    // redirect while streaming
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 0, 32'h40,       32'h0,        32'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1, 32'h44,       32'h40,       32'd17};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1, 32'h48,       32'h44,       32'd18};
    // misaligned redirect and PC wrap, then fill the queue
    vecs[16] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1, 32'h0,        32'hFFFF_FFFC, 32'h4000_0000};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h4,        32'hFFFF_FFFC, 32'h4000_0000};

    #1;
    check_all("reset0", 1'b0, 0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_i         = vecs[i].rst;
      ready_i       = vecs[i].rdy;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_count,
                vecs[i].e_pcaddr, vecs[i].e_pc, vecs[i].e_instr);
    end

    // Async reset between edges with a full queue: outputs clear before next edge.
    #2;
    rst_i = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 0, 32'h0, 32'h0, 32'h0);

    // Release reset and wait (bounded) for the first fetch to appear.
    @(negedge clk);
    rst_i   = 1'b1;
    ready_i = 1'b0;
    begin
      int n;
      n = 0;
      while (!valid_o && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("startup_wait_cycles", n, 1);
    end
    check_all("after_rel", 1'b1, 1, 32'h4, 32'h0, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
